// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Front end of the core. It is the only driver of Program_Counter's WrPC and
// address_bus inputs. It fetches each word from the synchronous program memory,
// splits the word into opcode and operand, and hands the instruction to the
// execute stage. It then computes the next PC (increment or taken branch) and
// stops when it decodes the HALT opcode.
//
// Ports
//   clk           system clock, all state on the rising edge
//   rst_n         asynchronous active-low reset
//   Instr         program memory read data (valid one cycle after Addr settles)
//   exec_ready    execute stage accepts the presented instruction
//   branch_taken  sampled only at the handshake; next PC = Operand
//   WrPC          write strobe to Program_Counter
//   address_bus   next-PC value to Program_Counter
//   instr_valid   Op/Operand valid for the execute stage
//   Op            opcode field of the current instruction
//   Operand       operand/address field of the current instruction
//   halted        HALT decoded; sticky until reset
//   instr_count   completed handshakes, saturating at 16'hFFFF
//
// Handshake: instr_valid/exec_ready follow strict valid/ready rules. While
// instr_valid is high, Op and Operand hold stable and instr_valid stays high.
// The instruction transfers on the first rising edge where both are high.
// instr_valid only rises after the transfer has moved the FSM through
// UPDATE and a new word has been fetched.
//
// Every output is a flop. The FSM state is held in state_q, an enumerated
// register, so that checkers can bind to it directly.
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int              AB      = 11,
    parameter int              OPW     = 5,
    parameter int              IW      = 16,
    parameter logic [OPW-1:0]  HALT_OP = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [IW-1:0]  Instr,
    input  logic           exec_ready,
    input  logic           branch_taken,
    output logic           WrPC,
    output logic [AB-1:0]  address_bus,
    output logic           instr_valid,
    output logic [OPW-1:0] Op,
    output logic [AB-1:0]  Operand,
    output logic           halted,
    output logic [15:0]    instr_count
);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_UPDATE = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [AB-1:0]  pc_q, pc_d;
    logic [AB-1:0]  next_q, next_d;

    logic           wrpc_d;
    logic [AB-1:0]  addr_d;
    logic           valid_d;
    logic [OPW-1:0] op_d;
    logic [AB-1:0]  operand_d;
    logic           halted_d;
    logic [15:0]    count_d;

    logic [AB-1:0]  pc_inc;
    logic [AB-1:0]  branch_target;

    // The increment wraps naturally at 2^AB.
    assign pc_inc        = pc_q + {{(AB-1){1'b0}}, 1'b1};
    assign branch_target = branch_taken ? Operand : pc_inc;

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            pc_q        <= '0;
            next_q      <= '0;
            WrPC        <= 1'b0;
            address_bus <= '0;
            instr_valid <= 1'b0;
            Op          <= '0;
            Operand     <= '0;
            halted      <= 1'b0;
            instr_count <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            next_q      <= next_d;
            WrPC        <= wrpc_d;
            address_bus <= addr_d;
            instr_valid <= valid_d;
            Op          <= op_d;
            Operand     <= operand_d;
            halted      <= halted_d;
            instr_count <= count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and next registered outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        next_d    = next_q;
        wrpc_d    = 1'b0;
        addr_d    = address_bus;
        valid_d   = instr_valid;
        op_d      = Op;
        operand_d = Operand;
        halted_d  = halted;
        count_d   = instr_count;

        case (state_q)
            // Program_Counter has no reset. INIT loads it with 0.
            // Because WrPC is a flop, the first cycle after reset raises the
            // strobe and the second cycle lowers it. The strobe is therefore
            // high for exactly one cycle before FETCH.
            S_INIT: begin
                if (!WrPC) begin
                    wrpc_d = 1'b1;
                    addr_d = '0;
                end else begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end

            // Addr is stable this cycle. The memory samples it on the
            // closing edge.
            S_FETCH: begin
                state_d = S_DECODE;
            end

            // Instr holds the word for pc_q.
            S_DECODE: begin
                if (Instr[IW-1:AB] == HALT_OP) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    op_d      = Instr[IW-1:AB];
                    operand_d = Instr[AB-1:0];
                    valid_d   = 1'b1;
                    state_d   = S_ISSUE;
                end
            end

            // instr_valid is high only in this state. A handshake therefore
            // reduces to exec_ready here. branch_taken is ignored while
            // stalled.
            S_ISSUE: begin
                if (exec_ready) begin
                    next_d  = branch_target;
                    addr_d  = branch_target;
                    wrpc_d  = 1'b1;
                    valid_d = 1'b0;
                    if (instr_count != 16'hFFFF) begin
                        count_d = instr_count + 16'd1;
                    end
                    state_d = S_UPDATE;
                end
            end

            // Program_Counter loads address_bus on the closing edge. pc_q
            // follows it on the same edge, so pc_q tracks Addr from here on.
            S_UPDATE: begin
                pc_d    = next_q;
                state_d = S_FETCH;
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_INIT;
            end
        endcase
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Upstream stage of Program_Counter: the only driver of its WrPC and address_bus inputs.
- Sequences instruction fetch from the synchronous program memory (addressed by the PC's Addr output) and splits each word into opcode/operand.
- Presents each instruction to the execute/control stage with a valid/ready handshake, computes next PC (increment or taken branch), and stops on the HALT opcode.

Parameters:
AB, 11, program address width; matches Program_Counter AB
OPW, 5, opcode width
IW, 16, instruction word width; must equal OPW+AB
HALT_OP, 5'b00000, opcode that stops the sequencer

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
Instr  input  IW  program memory read data, valid one cycle after Addr is stable
exec_ready  input  1  execute stage accepts the presented instruction
branch_taken  input  1  sampled only at handshake; next PC = Operand
WrPC  output  1  write strobe to Program_Counter
address_bus  output  AB  next-PC value to Program_Counter
instr_valid  output  1  Op/Operand valid for execute stage
Op  output  OPW  Instr[IW-1:AB] of current instruction
Operand  output  AB  Instr[AB-1:0] of current instruction
halted  output  1  HALT reached; sticky until reset
instr_count  output  16  instructions handed over (handshakes completed)

Behaviour:
- All outputs registered (Moore). Async reset: state=INIT, pc_q=0, next_q=0, WrPC=0, address_bus=0, instr_valid=0, Op=0, Operand=0, halted=0, instr_count=0. Applies immediately, including mid-handshake.
- Program_Counter has no reset, so INIT re-synchronises it:
- INIT: WrPC=1, address_bus=0 for exactly one cycle -> FETCH.
- FETCH: WrPC=0; Addr stable; memory read occurs at end of cycle -> DECODE.
- DECODE: Instr is valid this cycle.
  - Opcode == HALT_OP -> HALT. instr_valid never asserted; instr_count unchanged.
  - Otherwise capture Op/Operand into registers -> ISSUE.
- ISSUE: instr_valid=1, Op/Operand held stable.
  - Handshake = instr_valid && exec_ready at a rising edge.
  - On handshake: next_q = branch_taken ? Operand : pc_q+1 (mod 2^AB; 2^AB-1 wraps to 0); instr_count += 1, saturating at 16'hFFFF; -> UPDATE.
  - Without exec_ready: stay in ISSUE; all outputs unchanged; branch_taken ignored.
- UPDATE: WrPC=1, address_bus=next_q for exactly one cycle; pc_q<=next_q; instr_valid=0 -> FETCH.
- HALT: halted=1, WrPC=0, instr_valid=0. Exits only via reset.
- Invariants:
  - WrPC high only in INIT/UPDATE, one cycle each, never two consecutive cycles.
  - pc_q always equals the PC's Addr outside INIT/UPDATE.
- Minimum throughput: 4 cycles/instruction (UPDATE, FETCH, DECODE, ISSUE with exec_ready=1). No overlap/prefetch.
- Branch to the current address is legal (self-loop).
- Branch target == 2^AB-1 followed by a non-branch wraps to 0.

Test Plan:
- Release rst_n, exec_ready=1 -> cycle 1: WrPC=1, address_bus=0. Memory word 0x0801 (Op=1, Operand=1): instr_valid in cycle 4 with Op=1, Operand=0x001; cycle 5: WrPC=1, address_bus=1.
- Straight-line program of 5 non-HALT words then HALT at addr 5, exec_ready=1 -> WrPC pulses with address_bus 0,1,2,3,4,5 every 4 cycles; halted=1 after DECODE of addr 5; instr_count=5; no further WrPC.
- At addr 3, branch_taken=1, Operand=0x40 -> UPDATE drives address_bus=0x040; next fetch from 0x40; instr_count increments once.
- Branch to 0x7FF, non-branch word there -> next address_bus=0x000 (wrap).
- exec_ready=0 for 10 cycles in ISSUE, branch_taken toggling -> instr_valid held 1, Op/Operand constant, WrPC=0, count unchanged; on exec_ready=1, exactly one UPDATE.
- Assert rst_n=0 asynchronously mid-ISSUE -> instr_valid, WrPC, halted, instr_count drop to 0 before next edge; after release, INIT pulse with address_bus=0; also verify reset clears halted.
